// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle ARM data-processing shifter operand unit.
// Optional RRX for immediate-form ROR #0 is enabled by defining SHIFT_SEQ_RRX_EN.
module shift_sequencer #(
  parameter int STEP_LOG2 = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic        abort,
  input  logic [31:0] ir,
  input  logic [31:0] rm,
  input  logic [31:0] rs,
  input  logic        c_in,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        c_out
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  typedef enum logic [1:0] {SH_LSL = 2'b00, SH_LSR = 2'b01, SH_ASR = 2'b10, SH_ROR = 2'b11} sh_t;

  localparam logic [5:0] STEP = 6'(1 << STEP_LOG2);

  state_t      state, state_d;
  logic [31:0] work, nxt_work;
  logic [5:0]  rem, step;
  sh_t         op_q;
  logic        rrx_q, cin_q;
  logic        accept, last, nxt_c;

  logic [31:0] dec_val;
  sh_t         dec_type;
  logic [7:0]  dec_amt;
  logic        dec_imm, dec_rrx, dec_wrap;
  logic [5:0]  dec_n;

  logic [31:0] fill;
  logic [32:0] lsl_t, rsh_t;

  logic unused_bits;
  assign unused_bits = ^{ir[31:28], ir[24:12], rs[31:8]};

  assign ready  = (state != SHIFT);
  assign busy   = (state == SHIFT);
  assign done   = (state == DONE);
  assign accept = start && (state != SHIFT);

  // Operation decode at accept: effective amount n, RRX and register-ROR wrap cases
  always_comb begin
    dec_val  = rm;
    dec_type = SH_LSL;
    dec_amt  = '0;
    dec_imm  = 1'b0;
    dec_n    = '0;
    dec_rrx  = 1'b0;
    dec_wrap = 1'b0;
    if (ir[27:25] == 3'b000) begin
      dec_type = sh_t'(ir[6:5]);
      dec_imm  = ~ir[4];
      dec_amt  = ir[4] ? rs[7:0] : {3'b000, ir[11:7]};
    end else if (ir[27:25] == 3'b001) begin
      dec_val  = {24'h0, ir[7:0]};
      dec_type = SH_ROR;
      dec_amt  = {3'b000, ir[11:8], 1'b0};
    end
    if (dec_type == SH_ROR) begin
      if (dec_imm && (dec_amt == '0)) begin
`ifdef SHIFT_SEQ_RRX_EN
        dec_n   = 6'd1;
        dec_rrx = 1'b1;
`else
        dec_n   = '0;
`endif
      end else begin
        dec_n    = {1'b0, dec_amt[4:0]};
        dec_wrap = (dec_amt != '0) && (dec_amt[4:0] == '0);
      end
    end else if (dec_imm && (dec_type != SH_LSL) && (dec_amt == '0)) begin
      dec_n = 6'd32;
    end else if (dec_amt > 8'd33) begin
      dec_n = 6'd33;
    end else begin
      dec_n = dec_amt[5:0];
    end
  end

  // One step of up to STEP bits; right shifts pull bits in from the fill word,
  // which makes LSR/ASR/ROR/RRX a single datapath.
  always_comb begin
    step = (rem > STEP) ? STEP : rem;
    last = (rem <= STEP);
    case (op_q)
      SH_ASR:  fill = {32{work[31]}};
      SH_ROR:  fill = rrx_q ? {31'b0, cin_q} : work;
      default: fill = '0;
    endcase
    lsl_t = {1'b0, work} << step;
    rsh_t = 33'({fill, work, 1'b0} >> step);
    if (op_q == SH_LSL) begin
      nxt_work = lsl_t[31:0];
      nxt_c    = lsl_t[32];
    end else begin
      nxt_work = rsh_t[32:1];
      nxt_c    = rsh_t[0];
    end
  end

  always_comb begin
    state_d = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_d = ((dec_n == '0) || dec_wrap) ? DONE : SHIFT;
        else       state_d = IDLE;
      end
      SHIFT: begin
        if (abort)     state_d = IDLE;
        else if (last) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      result <= '0;
      c_out  <= 1'b0;
      work   <= '0;
      rem    <= '0;
      op_q   <= SH_LSL;
      rrx_q  <= 1'b0;
      cin_q  <= 1'b0;
    end else if (accept) begin
      work  <= dec_val;
      rem   <= dec_n;
      op_q  <= dec_type;
      rrx_q <= dec_rrx;
      cin_q <= c_in;
      if (dec_wrap) begin
        result <= dec_val;
        c_out  <= dec_val[31];
      end else if (dec_n == '0) begin
        result <= dec_val;
        c_out  <= c_in;
      end
    end else if ((state == SHIFT) && !abort) begin
      work <= nxt_work;
      rem  <= rem - step;
      if (last) begin
        result <= nxt_work;
        c_out  <= nxt_c;
      end
    end
  end

endmodule

// File: tb/tb_shift_sequencer.sv
// Self-checking bench for shift_sequencer (STEP_LOG2=3): directed cases plus
// randomized operations against a behavioural model of the shifter operand.
module tb_shift_sequencer;

  localparam int STEP = 8;

  logic        clk, rst_n, start, abort, c_in;
  logic [31:0] ir, rm, rs;
  logic        ready, busy, done, c_out;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_res;
  logic        last_c;

  shift_sequencer #(.STEP_LOG2(3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .ir(ir), .rm(rm), .rs(rs), .c_in(c_in),
    .ready(ready), .busy(busy), .done(done), .result(result), .c_out(c_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Shifter operand as the architecture defines it, with latency in cycles after accept.
  function automatic void model(input logic [31:0] m_ir, m_rm, m_rs, input logic m_c,
                                output logic [31:0] res, output logic c, output int lat);
    logic [31:0] v;
    logic [63:0] w;
    int amt, t, n;
    bit imm;
    v = m_rm; t = 0; amt = 0; imm = 0;
    if (m_ir[27:25] == 3'b000) begin
      t   = int'(m_ir[6:5]);
      imm = !m_ir[4];
      amt = m_ir[4] ? int'(m_rs[7:0]) : int'(m_ir[11:7]);
    end else if (m_ir[27:25] == 3'b001) begin
      v   = {24'h0, m_ir[7:0]};
      t   = 3;
      amt = 2 * int'(m_ir[11:8]);
    end
    res = v; c = m_c; lat = 1;
    if (t == 3) begin
      if (imm && amt == 0) begin
`ifdef SHIFT_SEQ_RRX_EN
        res = {m_c, v[31:1]}; c = v[0]; lat = 2;
`endif
        return;
      end
      n = amt % 32;
      if (n == 0) begin
        if (amt != 0) c = v[31];
        return;
      end
      res = (v >> n) | (v << (32 - n));
      c   = res[31];
      lat = 1 + (n + STEP - 1) / STEP;
      return;
    end
    if (imm && t != 0 && amt == 0) n = 32;
    else n = (amt > 33) ? 33 : amt;
    if (n == 0) return;
    lat = 1 + (n + STEP - 1) / STEP;
    case (t)
      0: begin w = {32'b0, v} << n; res = w[31:0]; c = w[32]; end
      1: begin w = {31'b0, v, 1'b0} >> n; res = w[32:1]; c = w[0]; end
      default: begin
        if (n >= 32) begin res = {32{v[31]}}; c = v[31]; end
        else begin res = 32'($signed(v) >>> n); c = v[n-1]; end
      end
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [31:0] t_ir, t_rm, t_rs, input logic t_c,
                       input logic [31:0] e_res, input logic e_c, input int e_lat, input bit b2b);
    int lat;
    if (!b2b) @(negedge clk);
    check({tag, ":ready"}, 32'(ready), 32'h1);
    ir = t_ir; rm = t_rm; rs = t_rs; c_in = t_c; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (e_lat > 1) check({tag, ":busy"}, 32'(busy), 32'h1);
    lat = 1;
    while (done !== 1'b1 && lat < 64) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ":latency"}, 32'(lat), 32'(e_lat));
    check({tag, ":result"}, result, e_res);
    check({tag, ":c_out"}, 32'(c_out), 32'(e_c));
    last_res = e_res;
    last_c   = e_c;
  endtask

  initial begin
    logic [31:0] r_ir, r_rm, r_rs, e_res;
    logic        r_c, e_c;
    int          e_lat, sel, dones;

    rst_n = 1'b0; start = 1'b0; abort = 1'b0; c_in = 1'b0;
    ir = '0; rm = '0; rs = '0;
    repeat (3) @(negedge clk);
    check("rst:ready", 32'(ready), 32'h1);
    check("rst:busy", 32'(busy), 32'h0);
    check("rst:done", 32'(done), 32'h0);
    check("rst:result", result, 32'h0);
    check("rst:c_out", 32'(c_out), 32'h0);
    rst_n = 1'b1;

    do_op("lsl4", 32'h0000_0200, 32'h1000_000F, 32'h0, 1'b0, 32'h0000_00F0, 1'b1, 2, 0);
    do_op("lsr_reg32", 32'h0000_0030, 32'h8000_0001, 32'h20, 1'b0, 32'h0, 1'b1, 5, 0);
    do_op("asr_reg40", 32'h0000_0050, 32'h8000_0000, 32'h28, 1'b0, 32'hFFFF_FFFF, 1'b1, 6, 1);
    do_op("imm_rot", 32'h0200_01FF, 32'h1234_5678, 32'h0, 1'b0, 32'hC000_003F, 1'b1, 2, 0);
`ifdef SHIFT_SEQ_RRX_EN
    do_op("ror0", 32'h0000_0060, 32'h0000_0003, 32'h0, 1'b1, 32'h8000_0001, 1'b1, 2, 0);
`else
    do_op("ror0", 32'h0000_0060, 32'h0000_0003, 32'h0, 1'b1, 32'h0000_0003, 1'b1, 1, 0);
`endif
    do_op("ror_reg32", 32'h0000_0070, 32'h8000_0001, 32'h20, 1'b0, 32'h8000_0001, 1'b1, 1, 1);
    do_op("lsl0", 32'h0000_0000, 32'hCAFE_F00D, 32'h0, 1'b1, 32'hCAFE_F00D, 1'b1, 1, 0);
    do_op("bypass", 32'h0400_0F80, 32'h0BAD_BEEF, 32'hFF, 1'b0, 32'h0BAD_BEEF, 1'b0, 1, 1);
    do_op("lsr_imm0", 32'h0000_0020, 32'h8000_0000, 32'h0, 1'b0, 32'h0, 1'b1, 5, 0);
    do_op("ror_reg0", 32'h0000_0070, 32'h8765_4321, 32'h100, 1'b1, 32'h8765_4321, 1'b1, 1, 0);

    // Register LSL by 33: re-pulsed start ignored, abort at k+3 returns to IDLE silently.
    @(negedge clk);
    ir = 32'h0000_0010; rs = 32'h21; rm = 32'hFFFF_FFFF; c_in = 1'b0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    check("abort:busy_k1", 32'(busy), 32'h1);
    @(negedge clk); start = 1'b1; rm = 32'h0;
    @(negedge clk); start = 1'b0; abort = 1'b1;
    check("abort:busy_k3", 32'(busy), 32'h1);
    check("abort:ready_k3", 32'(ready), 32'h0);
    @(negedge clk); abort = 1'b0;
    check("abort:ready_k4", 32'(ready), 32'h1);
    check("abort:busy_k4", 32'(busy), 32'h0);
    check("abort:result_held", result, last_res);
    check("abort:c_out_held", 32'(c_out), 32'(last_c));
    dones = 0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("abort:no_done", 32'(dones), 32'h0);

    // Reset mid-SHIFT with start asserted on the reset edge.
    ir = 32'h0000_0010; rs = 32'h21; rm = 32'h1357_9BDF; c_in = 1'b1; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); rst_n = 1'b0; start = 1'b1;
    @(negedge clk); rst_n = 1'b1; start = 1'b0;
    check("midrst:ready", 32'(ready), 32'h1);
    check("midrst:busy", 32'(busy), 32'h0);
    check("midrst:done", 32'(done), 32'h0);
    check("midrst:result", result, 32'h0);
    check("midrst:c_out", 32'(c_out), 32'h0);

    for (int i = 0; i < 200; i++) begin
      sel  = $urandom_range(0, 9);
      r_ir = $urandom;
      r_rm = $urandom;
      r_rs = $urandom;
      r_c  = 1'($urandom_range(0, 1));
      if (sel < 7) r_ir[27:25] = 3'b000;
      else if (sel < 9) r_ir[27:25] = 3'b001;
      else if (r_ir[27:26] == 2'b00) r_ir[27:25] = 3'b101;
      case ($urandom_range(0, 3))
        0: r_rs[7:0] = 8'($urandom_range(0, 40));
        1: r_rs[7:0] = 8'(32 * $urandom_range(0, 7));
        2: r_ir[11:7] = 5'd0;
        default: ;
      endcase
      model(r_ir, r_rm, r_rs, r_c, e_res, e_c, e_lat);
      do_op("rand", r_ir, r_rm, r_rs, r_c, e_res, e_c, e_lat, bit'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_sequencer.md
SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have parameter STEP_LOG2, default 3, log2 of the maximum shift bits applied per cycle; legal values are 0..4.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset, sampled on the rising edge of clk.
REQ-004 SHALL have port start, input, 1 bit: operation request, accepted on an edge where ready=1.
REQ-005 SHALL have port abort, input, 1 bit: cancels an operation in progress.
REQ-006 SHALL have port ir, input, 32 bits: instruction word, sampled at accept.
REQ-007 SHALL have ports rm and rs, input, 32 bits each: operand register and shift-amount register, sampled at accept.
REQ-008 SHALL have port c_in, input, 1 bit: current carry flag (SR bit 29), sampled at accept.
REQ-009 SHALL have port ready, output, 1 bit: a new start can be accepted.
REQ-010 SHALL have port busy, output, 1 bit: a shift is in progress.
REQ-011 SHALL have port done, output, 1 bit: one-cycle pulse marking result and c_out valid.
REQ-012 SHALL have ports result, output, 32 bits, and c_out, output, 1 bit: shifter operand and shifter carry-out.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE; ready=1 in IDLE and DONE, busy=1 only in SHIFT, done=1 only in DONE.
REQ-014 SHALL decode the operation at accept:
- ir[27:25]=000, ir[4]=0: value rm, amount ir[11:7], type ir[6:5].
- ir[27:25]=000, ir[4]=1: value rm, amount rs[7:0], type ir[6:5].
- ir[27:25]=001: value is zero-extended ir[7:0], amount 2*ir[11:8], type ROR.
- Any other class: bypass with amount 0.
REQ-015 SHALL treat type encodings as 00=LSL, 01=LSR, 10=ASR, 11=ROR.
REQ-016 SHALL, in the immediate-amount form, treat LSR #0 and ASR #0 as amount 32, and ROR #0 per REQ-027.
REQ-017 SHALL clamp the effective amount n of LSL, LSR and ASR to min(amount, 33).
REQ-018 SHALL, for ROR with register amount, use n = amount mod 32; if amount≠0 and n=0, the result is rm with c_out=rm[31], and the state goes directly to DONE.
REQ-019 SHALL, when n=0 (and REQ-018 does not apply), go IDLE/DONE to DONE with result = value and c_out = c_in.
REQ-020 SHALL, when n>0, enter SHIFT and each cycle shift by min(remaining, 2^STEP_LOG2).
- c_out = the last bit shifted out.
- LSL/LSR shift in zeros, ASR shifts in value[31], ROR rotates.
REQ-021 SHALL assert done in cycle k+1 when n=0, and in cycle k+1+ceil(n/2^STEP_LOG2) otherwise, where k is the accept edge.
REQ-022 SHALL hold result and c_out stable from done until the next accept.
REQ-023 SHALL accept start in DONE, giving back-to-back operations with no idle cycle.
REQ-024 SHALL ignore start while in SHIFT.
REQ-025 SHALL, on abort in SHIFT, return to IDLE next cycle with no done and with result and c_out unchanged.
- abort in IDLE or DONE has no effect.
- abort has priority over completion.

Reset
REQ-026 SHALL, on rst_n=0 at an edge, from any state and including mid-SHIFT, enter IDLE with ready=1, busy=0, done=0, result=0 and c_out=0; start is ignored on that edge.

Configuration
REQ-027 SHALL honour macro SHIFT_SEQ_RRX_EN for immediate-form ROR #0:
- When defined, perform RRX: result = {c_in, rm[31:1]}, c_out = rm[0], one SHIFT cycle, done at k+2.
- When undefined, perform bypass: result = rm, c_out = c_in, done at k+1.

Verification (STEP_LOG2=3)
REQ-028 SHALL cover: ir class 000, ir[4]=0, LSL #4, rm=0x1000000F, c_in=0 -> result 0x000000F0, c_out=1, done at k+2.
REQ-029 SHALL cover: register LSR with rs=0x20, rm=0x80000001 -> result 0x00000000, c_out=1, done at k+5; then register ASR with rs=0x28, rm=0x80000000 -> result 0xFFFFFFFF, c_out=1, done at k+6.
REQ-030 SHALL cover: class 001 with ir[11:8]=1, ir[7:0]=0xFF -> result 0xC000003F, c_out=1, done at k+2.
REQ-031 SHALL cover: immediate ROR #0 with rm=0x00000003, c_in=1:
- With SHIFT_SEQ_RRX_EN: result 0x80000001, c_out=1.
- Without it: result 0x00000003, c_out=1.
REQ-032 SHALL cover: register LSL with rs=0x21 and start re-pulsed mid-SHIFT -> second start ignored; abort at k+3 -> IDLE at k+4, no done; rst_n=0 mid-SHIFT -> all outputs at reset values next cycle.
